// File: rtl/traffic_pkg.sv
// traffic_pkg: phase/lamp types, route indices and lamp-bus decode for the junction controller
package traffic_pkg;
    typedef enum logic [3:0] {
        BLUE_GREEN, BLUE_AMBER, BLUE_CLEAR,
        BLACK_GREEN, BLACK_AMBER, BLACK_CLEAR,
        YELLOW_GREEN, YELLOW_AMBER, YELLOW_CLEAR
    } phase_e;
    typedef enum logic [1:0] {RED = 2'b00, AMBER = 2'b01, GREEN = 2'b10} lamp_e;
    localparam int BLUE = 2;
    localparam int BLACK = 1;
    localparam int YELLOW = 0;
    function automatic logic [5:0] lamps(input phase_e p);
        logic [5:0] r;
        r = {3{RED}};
        case (p)
            BLUE_GREEN:   r[2*BLUE +: 2] = GREEN;
            BLUE_AMBER:   r[2*BLUE +: 2] = AMBER;
            BLACK_GREEN:  r[2*BLACK +: 2] = GREEN;
            BLACK_AMBER:  r[2*BLACK +: 2] = AMBER;
            YELLOW_GREEN: r[2*YELLOW +: 2] = GREEN;
            YELLOW_AMBER: r[2*YELLOW +: 2] = AMBER;
            default:      r = {3{RED}};
        endcase
        return r;
    endfunction
endpackage

// File: rtl/traffic_light_controller_phase_timer.sv
// phase_timer: loadable down-counter with zero flag, reset to INIT
module phase_timer #(
    parameter int W = 2,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt <= INIT;
        else if (load) cnt <= load_val;
        else if (!zero) cnt <= cnt - W'(1);
    assign zero = cnt == '0;
endmodule

// File: rtl/traffic_light_controller.sv
// traffic_light_controller: fixed-time green/amber/clear rotation over blue, black and yellow routes
module traffic_light_controller
    import traffic_pkg::*;
#(
    parameter int GREEN_CYCLES = 4,
    parameter int AMBER_CYCLES = 2,
    parameter int CLEAR_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    output logic [5:0] R
);
    localparam int MAXGA = GREEN_CYCLES > AMBER_CYCLES ? GREEN_CYCLES : AMBER_CYCLES;
    localparam int MAXC = MAXGA > CLEAR_CYCLES ? MAXGA : CLEAR_CYCLES;
    localparam int W = MAXC > 1 ? $clog2(MAXC) : 1;
    localparam logic [W-1:0] G = W'(GREEN_CYCLES - 1);
    localparam logic [W-1:0] A = W'(AMBER_CYCLES - 1);
    localparam logic [W-1:0] C = W'(CLEAR_CYCLES - 1);
    phase_e state, nxt;
    logic [W-1:0] dur;
    logic bad, zero;
    phase_timer #(.W(W), .INIT(G)) u_tmr (
        .clk(clk), .reset(reset), .load(zero | bad), .load_val(dur), .zero(zero)
    );
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= BLUE_GREEN;
        else if (zero | bad) state <= nxt;
    // Illegal encodings force a reload into BLUE_GREEN regardless of the counter.
    always_comb begin
        bad = state > YELLOW_CLEAR;
        nxt = (bad || state == YELLOW_CLEAR) ? BLUE_GREEN : phase_e'(state + 4'd1);
        dur = nxt inside {BLUE_GREEN, BLACK_GREEN, YELLOW_GREEN} ? G :
              nxt inside {BLUE_AMBER, BLACK_AMBER, YELLOW_AMBER} ? A : C;
    end
    assign R = lamps(state);
endmodule

// File: tb/tb_traffic_light_controller.sv
// tb_traffic_light_controller: directed checks of rotation, reset behaviour, invariants and parameter variants
module tb_traffic_light_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [5:0] rd, ra, rb, pd, pa, pb;
    int n_run = 0;
    int n_fail = 0;
    logic [5:0] tbl [21] = '{
        6'b100000, 6'b100000, 6'b100000, 6'b100000, 6'b010000, 6'b010000, 6'b000000,
        6'b001000, 6'b001000, 6'b001000, 6'b001000, 6'b000100, 6'b000100, 6'b000000,
        6'b000010, 6'b000010, 6'b000010, 6'b000010, 6'b000001, 6'b000001, 6'b000000
    };

    traffic_light_controller dut_d (.clk(clk), .reset(rst_n), .R(rd));
    traffic_light_controller #(.GREEN_CYCLES(1), .AMBER_CYCLES(1), .CLEAR_CYCLES(1))
        dut_a (.clk(clk), .reset(rst_n), .R(ra));
    traffic_light_controller #(.GREEN_CYCLES(7), .AMBER_CYCLES(3), .CLEAR_CYCLES(2))
        dut_b (.clk(clk), .reset(rst_n), .R(rb));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // k = rising edges since reset release; blue green is visible for samples 0..g-1
    function automatic logic [5:0] model(input int g, input int a, input int c, input int k);
        int s, p, q;
        logic [5:0] v;
        s = g + a + c;
        p = k % (3 * s);
        q = p % s;
        v = {4'b0000, q < g ? 2'b10 : q < g + a ? 2'b01 : 2'b00};
        return v << (2 * (2 - p / s));
    endfunction

    task automatic inv(input string tag, input logic [5:0] cur, input logic [5:0] prev);
        int nonred;
        logic [2:0] c11, seq;
        nonred = 0;
        c11 = '0;
        seq = '0;
        for (int i = 0; i < 3; i++) begin
            nonred += int'(cur[2*i +: 2] != 2'b00);
            c11[i] = cur[2*i +: 2] == 2'b11;
            seq[i] = (prev[2*i +: 2] == 2'b10 && cur[2*i +: 2] == 2'b00) ||
                     (prev[2*i +: 2] == 2'b00 && cur[2*i +: 2] == 2'b01);
        end
        chk({tag, "_onehot"}, 6'(nonred > 1), 6'd0);
        chk({tag, "_code11"}, {3'b000, c11}, 6'd0);
        chk({tag, "_seq"}, {3'b000, seq}, 6'd0);
    endtask

    initial begin
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold", rd, 6'b100000);
            chk("rst_cnt", 6'(dut_d.u_tmr.cnt), 6'd3);
            chk("rst_hold_732", rb, 6'b100000);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 75; k++) begin
            if (k > 0) @(negedge clk);
            chk("rot_def", rd, tbl[k % 21]);
            chk("rot_111", ra, model(1, 1, 1, k));
            chk("rot_732", rb, model(7, 3, 2, k));
        end
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", rd, 6'b100000);
        chk("async_rst_111", ra, 6'b100000);
        chk("async_rst_732", rb, 6'b100000);
        @(negedge clk);
        chk("mid_rst_hold", rd, 6'b100000);
        chk("mid_rst_cnt", 6'(dut_d.u_tmr.cnt), 6'd3);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            chk("after_rst", rd, tbl[k]);
            chk("after_rst_732", rb, model(7, 3, 2, k));
        end
        pd = rd;
        pa = ra;
        pb = rb;
        repeat (500) begin
            @(negedge clk);
            inv("inv_def", rd, pd);
            inv("inv_111", ra, pa);
            inv("inv_732", rb, pb);
            pd = rd;
            pa = ra;
            pb = rb;
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
